pipe_if_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register for the five-stage pipelined CPU, sitting directly upstream of the decode-stage control unit. It owns the PC, issues fetches over a ready/valid instruction-memory handshake, and applies the control unit's `pcsource` and `wpcir` stall. Branches and jumps use a one-instruction delay slot. A pending-redirect register keeps a resolved target that would otherwise be lost while a fetch is waiting on memory.

---
 rtl/pipe_if_stage.sv | 142 ++++++++++++++
 tb/tb_pipe_if_stage.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the five-stage CPU.
// Owns the PC, fetches over a req/ready handshake, honours decode redirects and stalls.
module pipe_if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] da,
  input  logic [31:0] jpc,
  input  logic        wpcir,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic [31:0] dpc4,
  output logic        dvalid,
  output logic        dbg_state,
  output logic        dbg_redir_pend,
  output logic [31:0] dbg_redir_tgt
);

  typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

  state_t      state_q, state_n;
  logic        req_en_q;
  logic [31:0] pc_q, pc_n;
  logic [31:0] inst_q, inst_n;
  logic [31:0] dpc4_q, dpc4_n;
  logic        dvalid_q, dvalid_n;
  logic [31:0] hold_q, hold_n;
  logic        pend_q, pend_n;
  logic [31:0] tgt_q, tgt_n;

  logic [31:0] pc4, sel_tgt, id_tgt, next_pc;
  logic        id_redirect, fetch_done;

  // Handshake: a fetch of imem_addr completes on a rising edge where
  // imem_req and imem_ready are both 1; imem_ready is ignored otherwise and
  // imem_addr stays put until the request completes.
  assign imem_req   = req_en_q & (state_q == FETCH);
  assign fetch_done = imem_req & imem_ready;

  always_comb begin
    pc4 = pc_q + 32'd4;
    case (pcsource)
      2'b01:   sel_tgt = bpc;
      2'b10:   sel_tgt = da;
      2'b11:   sel_tgt = jpc;
      default: sel_tgt = pc4;
    endcase
    id_tgt      = sel_tgt & 32'hFFFF_FFFC;
    id_redirect = dvalid_q & wpcir & (pcsource != 2'b00);
    // A live ID redirect beats a parked one; the parked one beats sequential.
    if (id_redirect)  next_pc = id_tgt;
    else if (pend_q)  next_pc = tgt_q;
    else              next_pc = pc4;
  end

  always_comb begin
    state_n  = state_q;
    pc_n     = pc_q;
    inst_n   = inst_q;
    dpc4_n   = dpc4_q;
    dvalid_n = dvalid_q;
    hold_n   = hold_q;
    pend_n   = pend_q;
    tgt_n    = tgt_q;
    case (state_q)
      FETCH: begin
        if (fetch_done) begin
          if (wpcir) begin
            inst_n   = imem_rdata;
            dpc4_n   = pc4;
            dvalid_n = 1'b1;
            pc_n     = next_pc;
            pend_n   = 1'b0;
          end else begin
            hold_n  = imem_rdata;
            state_n = HOLD;
          end
        end else if (wpcir) begin
          // Fetch still outstanding: park the redirect so it is not lost.
          if (id_redirect) begin
            pend_n = 1'b1;
            tgt_n  = id_tgt;
          end
          inst_n   = 32'h0;
          dvalid_n = 1'b0;
        end
      end
      HOLD: begin
        if (wpcir) begin
          inst_n   = hold_q;
          dpc4_n   = pc4;
          dvalid_n = 1'b1;
          pc_n     = next_pc;
          pend_n   = 1'b0;
          state_n  = FETCH;
        end
      end
      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= FETCH;
      req_en_q <= 1'b0;
      pc_q     <= RESET_PC;
      inst_q   <= 32'h0;
      dpc4_q   <= 32'h0;
      dvalid_q <= 1'b0;
      hold_q   <= 32'h0;
      pend_q   <= 1'b0;
      tgt_q    <= 32'h0;
    end else begin
      state_q  <= state_n;
      req_en_q <= 1'b1;
      pc_q     <= pc_n;
      inst_q   <= inst_n;
      dpc4_q   <= dpc4_n;
      dvalid_q <= dvalid_n;
      hold_q   <= hold_n;
      pend_q   <= pend_n;
      tgt_q    <= tgt_n;
    end
  end

  assign imem_addr      = pc_q;
  assign pc             = pc_q;
  assign inst           = inst_q;
  assign dpc4           = dpc4_q;
  assign dvalid         = dvalid_q;
  assign dbg_state      = (state_q == HOLD);
  assign dbg_redir_pend = pend_q;
  assign dbg_redir_tgt  = tgt_q;

endmodule

// File: tb/tb_pipe_if_stage.sv
// Bench for pipe_if_stage: directed scenarios, then random memory waits, stalls and
// branches scored against an architectural instruction-stream model.
module tb_pipe_if_stage;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [1:0]  pcsource = 2'b00;
  logic [31:0] bpc = 32'h0, da = 32'h0, jpc = 32'h0;
  logic        wpcir = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready = 1'b0;
  logic [31:0] pc, inst, dpc4;
  logic        dvalid;
  logic        dbg_state, dbg_redir_pend;
  logic [31:0] dbg_redir_tgt;

  pipe_if_stage #(.RESET_PC(RPC)) dut (
    .clock(clock), .resetn(resetn), .pcsource(pcsource), .bpc(bpc), .da(da), .jpc(jpc),
    .wpcir(wpcir), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .pc(pc), .inst(inst), .dpc4(dpc4), .dvalid(dvalid),
    .dbg_state(dbg_state), .dbg_redir_pend(dbg_redir_pend), .dbg_redir_tgt(dbg_redir_tgt)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // Memory content is a fixed, never-zero function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction
  assign imem_rdata = mem_word(imem_addr);

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_id(input string nm, input logic [31:0] a);
    chk({nm, "_inst"}, inst, mem_word(a));
    chk({nm, "_dpc4"}, dpc4, a + 32'd4);
    chk({nm, "_dvalid"}, {31'h0, dvalid}, 32'd1);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];   // architectural addresses still to enter ID
  logic        mon_en = 1'b0;
  int          pop_cnt = 0;
  logic        held_m;
  logic        p_req, p_dvalid;
  logic [31:0] p_addr, p_inst, p_dpc4, p_pc;

  always begin
    logic w_s, r_s, done, exp_v;
    logic [31:0] e;
    @(posedge clock);
    w_s = wpcir;
    r_s = imem_ready;
    #1;
    if (!mon_en || !resetn) begin
      pop_cnt = 0;
      held_m  = 1'b0;
    end else begin
      done = p_req & r_s;
      chk("addr_eq_pc", imem_addr, pc);
      if (p_req && !r_s) chk("addr_stable", imem_addr, p_addr);
      if (w_s) begin
        exp_v = done | held_m;
        chk("dvalid", {31'h0, dvalid}, {31'h0, exp_v});
        if (dvalid) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL exp_q_empty act=entry exp=none t=%0t", $time);
          end else begin
            e = exp_q.pop_front();
            pop_cnt++;
            chk("sb_inst", inst, mem_word(e));
            chk("sb_dpc4", dpc4, e + 32'd4);
          end
        end else begin
          chk("bubble_inst", inst, 32'h0);
          chk("bubble_dpc4", dpc4, p_dpc4);
        end
        held_m = 1'b0;
      end else begin
        chk("stall_inst", inst, p_inst);
        chk("stall_dpc4", dpc4, p_dpc4);
        chk("stall_dvalid", {31'h0, dvalid}, {31'h0, p_dvalid});
        chk("stall_pc", pc, p_pc);
        if (done) held_m = 1'b1;
      end
      chk("req", {31'h0, imem_req}, {31'h0, ~held_m});
    end
    p_req = imem_req; p_addr = imem_addr; p_inst = inst;
    p_dpc4 = dpc4; p_dvalid = dvalid; p_pc = pc;
  end

  // ---------------- random driver ----------------
  int          ready_pct, go_pct, br_pct;
  int          last_dec, slot_idx;
  logic        cur_br;
  logic [1:0]  cur_src;
  logic [31:0] tail;

  task automatic drive_rand();
    logic [31:0] t;
    imem_ready = ($urandom_range(99) < ready_pct);
    wpcir      = ($urandom_range(99) < go_pct);
    bpc        = $urandom & 32'h0000_FFFF;
    da         = $urandom & 32'h0000_FFFF;
    jpc        = $urandom & 32'h0000_FFFF;
    if (dvalid) begin
      if (last_dec != pop_cnt) begin
        last_dec = pop_cnt;
        cur_br   = (pop_cnt != slot_idx) && ($urandom_range(99) < br_pct);
        cur_src  = 2'($urandom_range(1, 3));
      end
      pcsource = cur_br ? cur_src : 2'b00;
      if (wpcir) begin
        // The instruction leaves ID this edge; extend the expected stream.
        if (cur_br) begin
          case (cur_src)
            2'd1:    t = bpc;
            2'd2:    t = da;
            default: t = jpc;
          endcase
          t        = {t[31:2], 2'b00};
          slot_idx = pop_cnt + 1;
        end else begin
          t = tail + 32'd4;
        end
        exp_q.push_back(t);
        tail = t;
      end
    end else begin
      pcsource = 2'($urandom_range(0, 3));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    // reset state
    resetn = 1'b0; wpcir = 1'b1; pcsource = 2'b00; imem_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_pc", pc, RPC);
    chk("rst_inst", inst, 32'h0);
    chk("rst_dpc4", dpc4, 32'h0);
    chk("rst_dvalid", {31'h0, dvalid}, 32'd0);
    chk("rst_req", {31'h0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, RPC);
    chk("rst_state", {31'h0, dbg_state}, 32'd0);
    chk("rst_pend", {31'h0, dbg_redir_pend}, 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    #1;
    chk("first_cycle_req", {31'h0, imem_req}, 32'd0);

    // sequential zero-wait fetch
    step();
    for (int k = 0; k < 5; k++) begin
      chk("seq_addr", imem_addr, 32'(4 * k));
      chk("seq_req", {31'h0, imem_req}, 32'd1);
      chk("seq_dvalid", {31'h0, dvalid}, (k != 0) ? 32'd1 : 32'd0);
      if (k != 0) begin
        chk("seq_inst", inst, mem_word(32'(4 * (k - 1))));
        chk("seq_dpc4", dpc4, 32'(4 * k));
      end
      step();
    end

    // taken branch at 0x10 with delay slot
    chk_id("br_in_id", 32'h10);
    chk("br_addr0", imem_addr, 32'h14);
    pcsource = 2'b01; bpc = 32'h40; da = 32'h777; jpc = 32'h999;
    step();
    chk_id("br_slot", 32'h14);
    chk("br_addr1", imem_addr, 32'h40);
    pcsource = 2'b00;
    step();
    chk_id("br_tgt", 32'h40);
    chk("br_addr2", imem_addr, 32'h44);
    step();
    chk_id("pre_jr", 32'h44);

    // jr at 0x44 while the slot fetch of 0x48 waits 3 cycles
    imem_ready = 1'b0; pcsource = 2'b10; da = 32'h1003;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wait_dvalid", {31'h0, dvalid}, 32'd0);
      chk("wait_inst", inst, 32'h0);
      chk("wait_dpc4", dpc4, 32'h48);
      chk("wait_pend", {31'h0, dbg_redir_pend}, 32'd1);
      chk("wait_tgt", dbg_redir_tgt, 32'h1000);
      chk("wait_addr", imem_addr, 32'h48);
      pcsource = 2'b11; jpc = 32'h2000;
    end
    imem_ready = 1'b1; pcsource = 2'b00;
    step();
    chk_id("jr_slot", 32'h48);
    chk("jr_addr", imem_addr, 32'h1000);
    chk("jr_pend_clr", {31'h0, dbg_redir_pend}, 32'd0);

    // stall aligned with a completed fetch of 0x1000
    wpcir = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("hold_state", {31'h0, dbg_state}, 32'd1);
      chk("hold_req", {31'h0, imem_req}, 32'd0);
      chk_id("hold_id", 32'h48);
      chk("hold_pc", pc, 32'h1000);
    end
    wpcir = 1'b1;
    step();
    chk_id("hold_rel", 32'h1000);
    chk("hold_rel_state", {31'h0, dbg_state}, 32'd0);
    chk("hold_rel_addr", imem_addr, 32'h1004);

    // stall during a memory wait
    wpcir = 1'b0; imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("sw_pc", pc, 32'h1004);
      chk("sw_addr", imem_addr, 32'h1004);
      chk_id("sw_id", 32'h1000);
      chk("sw_req", {31'h0, imem_req}, 32'd1);
    end
    wpcir = 1'b1; imem_ready = 1'b1;
    step();
    chk_id("sw_rel", 32'h1004);

    // async reset while a fetch is pending with a parked redirect
    imem_ready = 1'b0; pcsource = 2'b01; bpc = 32'h80;
    step();
    chk("ar_pend_set", {31'h0, dbg_redir_pend}, 32'd1);
    pcsource = 2'b00;
    #2;
    resetn = 1'b0;
    #1;
    chk("ar_req", {31'h0, imem_req}, 32'd0);
    chk("ar_pc", pc, RPC);
    chk("ar_dvalid", {31'h0, dvalid}, 32'd0);
    chk("ar_pend", {31'h0, dbg_redir_pend}, 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    step();
    step();
    chk("ar_rel_pend", {31'h0, dbg_redir_pend}, 32'd0);
    chk("ar_rel_addr", imem_addr, RPC);
    imem_ready = 1'b1;
    step();
    chk_id("ar_first", RPC);
    chk("ar_next_addr", imem_addr, RPC + 32'd4);

    // random phase
    @(negedge clock);
    resetn = 1'b0;
    exp_q.delete();
    exp_q.push_back(RPC);
    exp_q.push_back(RPC + 32'd4);
    tail = RPC + 32'd4; slot_idx = -1; last_dec = 0; cur_br = 1'b0; cur_src = 2'b01;
    ready_pct = 100; go_pct = 100; br_pct = 25;
    wpcir = 1'b1; imem_ready = 1'b0; pcsource = 2'b00;
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #2;
    mon_en = 1'b1;
    for (int seg = 0; seg < 4; seg++) begin
      case (seg)
        0:       begin ready_pct = 100; go_pct = 100; end
        1:       begin ready_pct = 50;  go_pct = 80;  end
        2:       begin ready_pct = 25;  go_pct = 50;  end
        default: begin ready_pct = 70;  go_pct = 60;  end
      endcase
      repeat (700) begin
        @(negedge clock);
        drive_rand();
      end
    end
    @(negedge clock);
    wpcir = 1'b0; pcsource = 2'b00;
    @(posedge clock);
    #2;
    mon_en = 1'b0;
    chk("progress", (pop_cnt >= 600) ? 32'd1 : 32'd0, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
